// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; result lands WIDTH+1 cycles after the start edge.
// No backpressure: start is ignored while busy, and MTHI/MTLO only take effect in IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div;

  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  // op[0]==0 selects the signed variants; the most-negative value maps to its own unsigned magnitude
  assign sgn   = ~op[0];
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opd};
  assign div_next  = {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                      acc[WIDTH-2:0], ~div_diff[WIDTH]};

  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (zero_div) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = r_fix;
        lo_res = q_fix;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      opd         <= '0;
      a_raw       <= '0;
      acc         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_div <= op[1] & (b == '0);
            a_raw    <= a;
            cnt      <= CW'(WIDTH);
            if (op[1]) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opd <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opd <= a_mag;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          hi          <= hi_res;
          lo          <= lo_res;
          done        <= 1'b1;
          div_by_zero <= zero_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected HI/LO into a scoreboard,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   done_seen = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: one scoreboard entry per done pulse, plus latency and busy-length checks
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      busy_run = 0;
    end else begin
      if (div_by_zero && !done) chk("dbz_without_done", div_by_zero, 0);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("latency", cyc - e.cyc, W + 1);
          chk("busy_cycles", busy_run, W + 1);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Called at a negedge; leaves start low one negedge later with scrambled operands
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = ed;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_pending"}, sb.size(), 0);
    sb.delete();
    @(negedge clock);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, string name);
    issue(o, x, y, eh, el, ed);
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int seen0;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    #3 reset = 1'b0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    mthi  = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clock);
    mthi  = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_kept", lo, 0);

    run(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu");
    run(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, "mult_m1m1");
    run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg_a");
    run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_neg_b");
    run(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_zero");
    run(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_zero");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");

    // mtlo and a second start while busy must both be dropped
    issue(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
    repeat (5) @(negedge clock);
    mtlo  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    start = 1'b1;
    op    = 2'b01;
    a     = 32'h3;
    b     = 32'h3;
    @(negedge clock);
    mtlo  = 1'b0;
    start = 1'b0;
    wait_drain("busy_ignore");
    repeat (3) @(negedge clock);
    chk("busy_ignore_lo", lo, 32'h0000_000E);
    chk("busy_ignore_idle", busy, 0);

    // start wins over a simultaneous mthi in IDLE
    mthi  = 1'b1;
    wdata = 32'hAAAA_AAAA;
    issue(2'b01, 32'h2, 32'h3, 32'h0, 32'h6, 1'b0);
    mthi  = 1'b0;
    wait_drain("start_wins");

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h5555_AAAA;
    @(negedge clock);
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk("mthilo_hi", hi, 32'h5555_AAAA);
    chk("mthilo_lo", lo, 32'h5555_AAAA);

    // Back-to-back: second start issued in the done cycle of the first
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_first_done", done, 1);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    wait_drain("b2b");

    // Abort a DIVU with reset: registers clear and no done ever appears for it
    start = 1'b1;
    op    = 2'b11;
    a     = 32'h0000_1000;
    b     = 32'h0000_0003;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    seen0 = done_seen;
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    chk("abort_no_done", done_seen - seen0, 0);
    chk("abort_hi_after", hi, 0);
    chk("abort_lo_after", lo, 0);
    chk("abort_idle_after", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
